// File: rtl/fp_regfile_sb.sv
// FPU register file (2R/1W) with per-register scoreboard busy bits; FP_REGFILE_BYPASS_EN adds write-to-read forwarding.
// Latency: reads, busy flags and iss_accept are combinational; writes, reservations and pend_count land on the next clk edge.
// Backpressure: iss_accept=0 on a WAW hazard; the issuer holds iss_en/iss_addr and retries.
module fp_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rl_addr,
  input  logic [ADDR_W-1:0] rr_addr,
  output logic [DATA_W-1:0] rl_data,
  output logic [DATA_W-1:0] rr_data,
  output logic              rl_busy,
  output logic              rr_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_accept,
  output logic [DEPTH-1:0]  busy_vec,
  output logic [CNT_W-1:0]  pend_count
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [CNT_W-1:0]  pend_q;

  logic rl_in, rr_in, wr_in, iss_in;
  logic wr_fire, same_reg, pend_inc, pend_dec;
  logic rl_fwd, rr_fwd;

  // Addresses at or beyond DEPTH only exist when DEPTH is not a power of two.
  assign rl_in  = ({1'b0, rl_addr}  < DEPTH_L);
  assign rr_in  = ({1'b0, rr_addr}  < DEPTH_L);
  assign wr_in  = ({1'b0, wr_addr}  < DEPTH_L);
  assign iss_in = ({1'b0, iss_addr} < DEPTH_L);

  assign wr_fire  = wr_en & ~rst & wr_in;
  assign same_reg = (wr_addr == iss_addr);

  // A same-cycle writeback to the destination frees it before the new reservation.
  assign iss_accept = iss_en & ~rst & iss_in &
                      (~busy_q[iss_addr] | (wr_fire & same_reg));

`ifdef FP_REGFILE_BYPASS_EN
  assign rl_fwd = wr_fire & (wr_addr == rl_addr);
  assign rr_fwd = wr_fire & (wr_addr == rr_addr);
`else
  assign rl_fwd = 1'b0;
  assign rr_fwd = 1'b0;
`endif

  always_comb begin
    rl_data = '0;
    rr_data = '0;
    rl_busy = 1'b0;
    rr_busy = 1'b0;
    if (rl_fwd) begin
      rl_data = wr_data;
    end else if (rl_in) begin
      rl_data = regs[rl_addr];
      rl_busy = busy_q[rl_addr];
    end
    if (rr_fwd) begin
      rr_data = wr_data;
    end else if (rr_in) begin
      rr_data = regs[rr_addr];
      rr_busy = busy_q[rr_addr];
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (wr_fire) busy_d[wr_addr] = 1'b0;
    if (iss_accept) busy_d[iss_addr] = 1'b1;
  end

  // Count only real bit transitions so pend_count tracks popcount(busy_vec).
  assign pend_inc = iss_accept & ~busy_q[iss_addr];
  assign pend_dec = wr_fire & busy_q[wr_addr] & ~(iss_accept & same_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_q + CNT_W'(pend_inc) - CNT_W'(pend_dec);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_fire) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign busy_vec   = busy_q;
  assign pend_count = pend_q;

endmodule

// File: tb/tb_fp_regfile_sb.sv
// Directed bench for fp_regfile_sb: default 32x32 instance plus a 16-bit x 12-entry instance.
module tb_fp_regfile_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic [4:0]  rl_addr, rr_addr, wr_addr, iss_addr;
  logic [31:0] rl_data, rr_data, wr_data;
  logic        rl_busy, rr_busy, wr_en, iss_en, iss_accept;
  logic [31:0] busy_vec;
  logic [5:0]  pend_count;

  // DATA_W=16, DEPTH=12 instance
  logic [3:0]  p_rl_addr, p_rr_addr, p_wr_addr, p_iss_addr;
  logic [15:0] p_rl_data, p_rr_data, p_wr_data;
  logic        p_rl_busy, p_rr_busy, p_wr_en, p_iss_en, p_iss_accept;
  logic [11:0] p_busy_vec;
  logic [3:0]  p_pend_count;

  int checks = 0;
  int errors = 0;

  fp_regfile_sb dut (
    .clk(clk), .rst(rst),
    .rl_addr(rl_addr), .rr_addr(rr_addr), .rl_data(rl_data), .rr_data(rr_data),
    .rl_busy(rl_busy), .rr_busy(rr_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_accept(iss_accept),
    .busy_vec(busy_vec), .pend_count(pend_count)
  );

  fp_regfile_sb #(.DATA_W(16), .DEPTH(12)) dut_p (
    .clk(clk), .rst(rst),
    .rl_addr(p_rl_addr), .rr_addr(p_rr_addr), .rl_data(p_rl_data), .rr_data(p_rr_data),
    .rl_busy(p_rl_busy), .rr_busy(p_rr_busy),
    .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
    .iss_en(p_iss_en), .iss_addr(p_iss_addr), .iss_accept(p_iss_accept),
    .busy_vec(p_busy_vec), .pend_count(p_pend_count)
  );

  // Inputs change 1 time unit after posedge; outputs are sampled 2 units after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    wr_en = 0; iss_en = 0; p_wr_en = 0; p_iss_en = 0;
  endtask

  task automatic test_reset();
    rl_addr = 0; rr_addr = 0; wr_addr = 0; iss_addr = 0; wr_data = 0;
    p_rl_addr = 0; p_rr_addr = 0; p_wr_addr = 0; p_iss_addr = 0; p_wr_data = 0;
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    rl_addr = 3; rr_addr = 31;
    settle();
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy_vec got %h exp %h", busy_vec, 32'h0); end
    checks++; if (pend_count !== 6'd0) begin errors++; $display("FAIL reset_pend got %0d exp 0", pend_count); end
    checks++; if (rl_data !== 32'h0 || rr_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h/%h exp 0/0", rl_data, rr_data); end
    checks++; if (rl_busy !== 1'b0 || rr_busy !== 1'b0) begin errors++; $display("FAIL reset_rbusy got %b%b exp 00", rl_busy, rr_busy); end
    checks++; if (p_pend_count !== 4'd0) begin errors++; $display("FAIL reset_p_pend got %0d exp 0", p_pend_count); end
    wr_en = 1; wr_addr = 0; wr_data = 32'd12;
    tick();
    wr_addr = 1; wr_data = 32'd16;
    tick();
    idle();
    rr_addr = 0; rl_addr = 1;
    settle();
    checks++; if (rr_data !== 32'd12) begin errors++; $display("FAIL init_rr_data got %0d exp 12", rr_data); end
    checks++; if (rl_data !== 32'd16) begin errors++; $display("FAIL init_rl_data got %0d exp 16", rl_data); end
    checks++; if (rl_busy !== 1'b0 || rr_busy !== 1'b0) begin errors++; $display("FAIL init_busy got %b%b exp 00", rl_busy, rr_busy); end
    checks++; if (pend_count !== 6'd0) begin errors++; $display("FAIL init_pend got %0d exp 0", pend_count); end
  endtask

  task automatic test_raw();
    iss_en = 1; iss_addr = 5;
    settle();
    checks++; if (iss_accept !== 1'b1) begin errors++; $display("FAIL raw_accept got %b exp 1", iss_accept); end
    tick();
    idle();
    rl_addr = 5;
    settle();
    checks++; if (busy_vec[5] !== 1'b1) begin errors++; $display("FAIL raw_busy5 got %b exp 1", busy_vec[5]); end
    checks++; if (pend_count !== 6'd1) begin errors++; $display("FAIL raw_pend got %0d exp 1", pend_count); end
    checks++; if (rl_busy !== 1'b1) begin errors++; $display("FAIL raw_rl_busy got %b exp 1", rl_busy); end
    wr_en = 1; wr_addr = 5; wr_data = 32'h3F800000;
    tick();
    idle();
    settle();
    checks++; if (rl_busy !== 1'b0) begin errors++; $display("FAIL raw_release got %b exp 0", rl_busy); end
    checks++; if (rl_data !== 32'h3F800000) begin errors++; $display("FAIL raw_data got %h exp 3f800000", rl_data); end
    checks++; if (pend_count !== 6'd0) begin errors++; $display("FAIL raw_pend_after got %0d exp 0", pend_count); end
  endtask

  task automatic test_waw();
    iss_en = 1; iss_addr = 5;
    tick();
    iss_en = 1; iss_addr = 5;
    settle();
    checks++; if (iss_accept !== 1'b0) begin errors++; $display("FAIL waw_reject got %b exp 0", iss_accept); end
    tick();
    checks++; if (pend_count !== 6'd1 || busy_vec !== 32'h20) begin errors++; $display("FAIL waw_hold got %0d/%h exp 1/00000020", pend_count, busy_vec); end
    wr_en = 1; wr_addr = 5; wr_data = 32'h40000000;
    settle();
    checks++; if (iss_accept !== 1'b1) begin errors++; $display("FAIL waw_wb_accept got %b exp 1", iss_accept); end
    tick();
    idle();
    rl_addr = 5;
    settle();
    checks++; if (busy_vec !== 32'h20 || pend_count !== 6'd1) begin errors++; $display("FAIL waw_same_reg got %h/%0d exp 00000020/1", busy_vec, pend_count); end
    checks++; if (rl_data !== 32'h40000000) begin errors++; $display("FAIL waw_data got %h exp 40000000", rl_data); end
  endtask

  task automatic test_simul_diff();
    // release reg5 while reserving reg6, then write non-busy reg8 while reserving reg2
    wr_en = 1; wr_addr = 5; wr_data = 32'h1;
    iss_en = 1; iss_addr = 6;
    tick();
    checks++; if (busy_vec !== 32'h40 || pend_count !== 6'd1) begin errors++; $display("FAIL diff_swap got %h/%0d exp 00000040/1", busy_vec, pend_count); end
    wr_addr = 8; wr_data = 32'h55; iss_addr = 2;
    tick();
    idle();
    rl_addr = 8;
    settle();
    checks++; if (busy_vec !== 32'h44 || pend_count !== 6'd2) begin errors++; $display("FAIL diff_init_wr got %h/%0d exp 00000044/2", busy_vec, pend_count); end
    checks++; if (rl_data !== 32'h55 || rl_busy !== 1'b0) begin errors++; $display("FAIL diff_data got %h/%b exp 00000055/0", rl_data, rl_busy); end
  endtask

  task automatic test_reset_mid();
    wr_en = 1; wr_addr = 6; wr_data = 32'h6;
    iss_en = 1; iss_addr = 7;
    tick();
    wr_en = 0; iss_addr = 9;
    tick();
    idle();
    checks++; if (busy_vec !== 32'h284 || pend_count !== 6'd3) begin errors++; $display("FAIL mid_setup got %h/%0d exp 00000284/3", busy_vec, pend_count); end
    rst = 1;
    wr_en = 1; wr_addr = 2; wr_data = 32'hFFFF;
    iss_en = 1; iss_addr = 3;
    settle();
    checks++; if (iss_accept !== 1'b0) begin errors++; $display("FAIL mid_accept got %b exp 0", iss_accept); end
    tick();
    rst = 0;
    idle();
    rl_addr = 2; rr_addr = 0;
    settle();
    checks++; if (busy_vec !== 32'h0 || pend_count !== 6'd0) begin errors++; $display("FAIL mid_clear got %h/%0d exp 0/0", busy_vec, pend_count); end
    checks++; if (rl_data !== 32'h0 || rr_data !== 32'h0) begin errors++; $display("FAIL mid_regs got %h/%h exp 0/0", rl_data, rr_data); end
  endtask

  task automatic test_bypass();
    iss_en = 1; iss_addr = 4;
    tick();
    idle();
    rl_addr = 4; rr_addr = 4;
    wr_en = 1; wr_addr = 4; wr_data = 32'hDEADBEEF;
    settle();
`ifdef FP_REGFILE_BYPASS_EN
    checks++; if (rl_data !== 32'hDEADBEEF || rr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_data got %h/%h exp deadbeef", rl_data, rr_data); end
    checks++; if (rl_busy !== 1'b0 || rr_busy !== 1'b0) begin errors++; $display("FAIL byp_busy got %b%b exp 00", rl_busy, rr_busy); end
`else
    checks++; if (rl_data !== 32'h0 || rr_data !== 32'h0) begin errors++; $display("FAIL nobyp_data got %h/%h exp 0", rl_data, rr_data); end
    checks++; if (rl_busy !== 1'b1 || rr_busy !== 1'b1) begin errors++; $display("FAIL nobyp_busy got %b%b exp 11", rl_busy, rr_busy); end
`endif
    tick();
    idle();
    settle();
    checks++; if (rl_data !== 32'hDEADBEEF || rr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_next_data got %h/%h exp deadbeef", rl_data, rr_data); end
    checks++; if (rl_busy !== 1'b0 || pend_count !== 6'd0) begin errors++; $display("FAIL byp_next_busy got %b/%0d exp 0/0", rl_busy, pend_count); end
  endtask

  task automatic test_param();
    int acc;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      p_iss_en = 1; p_iss_addr = 4'(i);
      settle();
      if (p_iss_accept === 1'b1) acc++;
      tick();
    end
    idle();
    settle();
    checks++; if (acc !== 12) begin errors++; $display("FAIL p_fill_accepts got %0d exp 12", acc); end
    checks++; if (p_pend_count !== 4'd12 || p_busy_vec !== 12'hFFF) begin errors++; $display("FAIL p_full got %0d/%h exp 12/fff", p_pend_count, p_busy_vec); end
    p_iss_en = 1; p_iss_addr = 13;
    settle();
    checks++; if (p_iss_accept !== 1'b0) begin errors++; $display("FAIL p_oor_accept got %b exp 0", p_iss_accept); end
    p_iss_en = 0;
    p_wr_en = 1; p_wr_addr = 13; p_wr_data = 16'h1234;
    tick();
    p_wr_addr = 11; p_wr_data = 16'hABCD;
    tick();
    idle();
    p_rl_addr = 13; p_rr_addr = 11;
    settle();
    checks++; if (p_rl_data !== 16'h0 || p_rl_busy !== 1'b0) begin errors++; $display("FAIL p_oor_read got %h/%b exp 0/0", p_rl_data, p_rl_busy); end
    checks++; if (p_rr_data !== 16'hABCD || p_rr_busy !== 1'b0) begin errors++; $display("FAIL p_wr11 got %h/%b exp abcd/0", p_rr_data, p_rr_busy); end
    checks++; if (p_pend_count !== 4'd11 || p_busy_vec !== 12'h7FF) begin errors++; $display("FAIL p_release got %0d/%h exp 11/7ff", p_pend_count, p_busy_vec); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw();
    test_simul_diff();
    test_reset_mid();
    test_bypass();
    test_param();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
